// File: rtl/sseg_view_sched.sv
// rtl/sseg_view_sched.sv - game-level view scheduler for the 4-digit 7-seg display
module sseg_view_sched #(
  parameter int TICKS_PER_SEC = 65_000_000,
  parameter int TURN_SECS     = 15,
  parameter int BLINK_TICKS   = 32_500_000,
  parameter int MAX_SCORE     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       turn_start,
  input  logic       turn_end,
  input  logic       player_sel,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic [3:0] num_1,
  output logic [3:0] num_2,
  output logic       disp_en,
  output logic       timeout,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2
);

  localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [3:0]    SECS_INIT  = 4'(TURN_SECS);
  localparam logic [3:0]    SCORE_MAX  = 4'(MAX_SCORE);

  typedef enum logic [1:0] {S_IDLE, S_SCORE, S_TIMER, S_END} state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [3:0]    r_sec, w_sec_nxt;
  logic          r_player, w_player_nxt;
  logic [BW-1:0] r_blink, w_blink_nxt;
  logic          r_lit, w_lit_nxt;
  logic          r_expired, w_expired_nxt;
  logic [3:0]    r_score_p1, w_score_p1_nxt;
  logic [3:0]    r_score_p2, w_score_p2_nxt;
  logic [3:0]    r_num_1, r_num_2;
  logic          r_disp_en, r_timeout;
  logic          w_active;
  logic          w_tick_wrap;

  assign w_active    = (r_state == S_SCORE) || (r_state == S_TIMER);
  assign w_tick_wrap = (r_tick == TICK_LAST);

  // Next-state: hits first, then the event priority chain overrides as needed
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = r_tick;
    w_sec_nxt      = r_sec;
    w_player_nxt   = r_player;
    w_blink_nxt    = r_blink;
    w_lit_nxt      = r_lit;
    w_expired_nxt  = 1'b0;
    w_score_p1_nxt = r_score_p1;
    w_score_p2_nxt = r_score_p2;

    if (w_active && hit_p1 && (r_score_p1 < SCORE_MAX)) w_score_p1_nxt = r_score_p1 + 4'd1;
    if (w_active && hit_p2 && (r_score_p2 < SCORE_MAX)) w_score_p2_nxt = r_score_p2 + 4'd1;

    if ((r_state != S_IDLE) && game_over) begin
      // the hit applied above still lands; the scores freeze from here on
      w_state_nxt = S_END;
      w_blink_nxt = '0;
      w_lit_nxt   = 1'b1;
    end else if (game_start) begin
      w_state_nxt    = S_SCORE;
      w_score_p1_nxt = 4'd0;
      w_score_p2_nxt = 4'd0;
      w_tick_nxt     = '0;
      w_sec_nxt      = 4'd0;
      w_blink_nxt    = '0;
      w_lit_nxt      = 1'b0;
    end else begin
      case (r_state)
        S_SCORE: begin
          if (turn_start) begin
            w_state_nxt  = S_TIMER;
            w_sec_nxt    = SECS_INIT;
            w_tick_nxt   = '0;
            w_player_nxt = player_sel;
          end
        end
        S_TIMER: begin
          if (turn_end) begin
            w_state_nxt = S_SCORE;
            w_tick_nxt  = '0;
          end else if (w_tick_wrap && (r_sec == 4'd0)) begin
            w_state_nxt   = S_SCORE;
            w_tick_nxt    = '0;
            w_expired_nxt = 1'b1;
          end else if (turn_start) begin
            w_sec_nxt    = SECS_INIT;
            w_tick_nxt   = '0;
            w_player_nxt = player_sel;
          end else if (w_tick_wrap) begin
            w_tick_nxt = '0;
            w_sec_nxt  = r_sec - 4'd1;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
        S_END: begin
          if (r_blink == BLINK_LAST) begin
            w_blink_nxt = '0;
            w_lit_nxt   = ~r_lit;
          end else begin
            w_blink_nxt = r_blink + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter and score registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_sec      <= 4'd0;
      r_player   <= 1'b0;
      r_blink    <= '0;
      r_lit      <= 1'b0;
      r_expired  <= 1'b0;
      r_score_p1 <= 4'd0;
      r_score_p2 <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick_nxt;
      r_sec      <= w_sec_nxt;
      r_player   <= w_player_nxt;
      r_blink    <= w_blink_nxt;
      r_lit      <= w_lit_nxt;
      r_expired  <= w_expired_nxt;
      r_score_p1 <= w_score_p1_nxt;
      r_score_p2 <= w_score_p2_nxt;
    end
  end

  // Registered view: decoded from the current state, visible one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_1   <= 4'd0;
      r_num_2   <= 4'd0;
      r_disp_en <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= r_expired;
      case (r_state)
        S_SCORE: begin
          r_num_1   <= r_score_p1;
          r_num_2   <= r_score_p2;
          r_disp_en <= 1'b1;
        end
        S_TIMER: begin
          r_num_1   <= {3'b000, r_player} + 4'd1;
          r_num_2   <= r_sec;
          r_disp_en <= 1'b1;
        end
        S_END: begin
          r_num_1   <= r_score_p1;
          r_num_2   <= r_score_p2;
          r_disp_en <= r_lit;
        end
        default: begin
          r_num_1   <= 4'd0;
          r_num_2   <= 4'd0;
          r_disp_en <= 1'b0;
        end
      endcase
    end
  end

  assign num_1    = r_num_1;
  assign num_2    = r_num_2;
  assign disp_en  = r_disp_en;
  assign timeout  = r_timeout;
  assign score_p1 = r_score_p1;
  assign score_p2 = r_score_p2;

endmodule

// File: tb/tb_sseg_view_sched.sv
// tb/tb_sseg_view_sched.sv - self-checking bench for sseg_view_sched
module tb_sseg_view_sched;

  localparam int TPS = 4;
  localparam int TS  = 3;
  localparam int BT  = 2;
  localparam int MS  = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_start = 1'b0, game_over = 1'b0, turn_start = 1'b0, turn_end = 1'b0;
  logic       player_sel = 1'b0, hit_p1 = 1'b0, hit_p2 = 1'b0;
  logic [3:0] num_1, num_2, score_p1, score_p2;
  logic       disp_en, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // model: mode 0=idle 1=score 2=timer 3=end
  int m_mode = 0, m_s1 = 0, m_s2 = 0, m_turn_k = 0, m_player = 0, m_end_k = 0;
  bit m_exp = 1'b0;
  bit m_valid = 1'b0;
  int e_n1 = 0, e_n2 = 0, e_de = 0, e_to = 0, e_s1 = 0, e_s2 = 0;

  sseg_view_sched #(
    .TICKS_PER_SEC(TPS), .TURN_SECS(TS), .BLINK_TICKS(BT), .MAX_SCORE(MS)
  ) dut (
    .clk(clk), .rst(rst),
    .game_start(game_start), .game_over(game_over),
    .turn_start(turn_start), .turn_end(turn_end),
    .player_sel(player_sel), .hit_p1(hit_p1), .hit_p2(hit_p2),
    .num_1(num_1), .num_2(num_2), .disp_en(disp_en), .timeout(timeout),
    .score_p1(score_p1), .score_p2(score_p2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int sat_inc(input int s);
    return (s + 1 > MS) ? MS : s + 1;
  endfunction

  // behavioural model: elapsed-cycle arithmetic per game phase
  initial forever begin
    @(posedge clk);
    if (rst) begin
      e_n1 = 0; e_n2 = 0; e_de = 0; e_to = 0;
      m_mode = 0; m_s1 = 0; m_s2 = 0; m_turn_k = 0; m_player = 0; m_end_k = 0;
      m_exp = 1'b0; m_valid = 1'b1;
    end else begin
      case (m_mode)
        1: begin e_n1 = m_s1; e_n2 = m_s2; e_de = 1; end
        2: begin e_n1 = m_player + 1; e_n2 = TS - m_turn_k / TPS; e_de = 1; end
        3: begin e_n1 = m_s1; e_n2 = m_s2; e_de = ((m_end_k / BT) % 2 == 0) ? 1 : 0; end
        default: begin e_n1 = 0; e_n2 = 0; e_de = 0; end
      endcase
      e_to = m_exp ? 1 : 0;
      m_exp = 1'b0;
      if ((m_mode == 1 || m_mode == 2) && !game_start) begin
        if (hit_p1) m_s1 = sat_inc(m_s1);
        if (hit_p2) m_s2 = sat_inc(m_s2);
      end else if ((m_mode == 1 || m_mode == 2) && game_over) begin
        if (hit_p1) m_s1 = sat_inc(m_s1);
        if (hit_p2) m_s2 = sat_inc(m_s2);
      end
      if (m_mode != 0 && game_over) begin
        m_mode = 3; m_end_k = 0;
      end else if (game_start) begin
        m_mode = 1; m_s1 = 0; m_s2 = 0;
      end else if (m_mode == 1) begin
        if (turn_start) begin m_mode = 2; m_turn_k = 0; m_player = player_sel; end
      end else if (m_mode == 2) begin
        if (turn_end) m_mode = 1;
        else if (m_turn_k + 1 == (TS + 1) * TPS) begin m_mode = 1; m_exp = 1'b1; end
        else if (turn_start) begin m_turn_k = 0; m_player = player_sel; end
        else m_turn_k++;
      end else if (m_mode == 3) begin
        m_end_k++;
      end
    end
    e_s1 = m_s1;
    e_s2 = m_s2;
  end

  // per-cycle compare of all outputs against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("num_1", num_1, e_n1);
      chk("num_2", num_2, e_n2);
      chk("disp_en", disp_en, e_de);
      chk("timeout", timeout, e_to);
      chk("score_p1", score_p1, e_s1);
      chk("score_p2", score_p2, e_s2);
    end
  end

  task automatic cyc(input bit r, input bit gs, input bit go, input bit ts,
                     input bit te, input bit h1, input bit h2);
    @(negedge clk);
    rst = r; game_start = gs; game_over = go; turn_start = ts;
    turn_end = te; hit_p1 = h1; hit_p2 = h2;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  int sec_tab[16] = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0};
  int blink_tab[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  int to_seen;

  initial begin
    // reset and idle
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_disp_en", disp_en, 0);
    chk("rst_num_1", num_1, 0);
    chk("rst_timeout", timeout, 0);
    idle(10);
    chk("idle_disp_en", disp_en, 0);
    chk("idle_num_2", num_2, 0);

    // scoring
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_score_p1", score_p1, 3);
    chk("lit_score_p2", score_p2, 2);
    idle(1);
    chk("score_view_n1", num_1, 3);
    chk("score_view_n2", num_2, 2);
    chk("score_view_de", disp_en, 1);

    // full countdown, player 2
    player_sel = 1'b1;
    cyc(0, 0, 0, 1, 0, 0, 0);
    player_sel = 1'b0;
    to_seen = 0;
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      chk("tmr_num_1", num_1, 2);
      chk("tmr_num_2", num_2, sec_tab[k-1]);
      if (timeout) to_seen++;
    end
    chk("to_early", to_seen, 0);
    idle(1);
    chk("to_at_17", timeout, 1);
    chk("to_view_n1", num_1, 3);
    idle(1);
    chk("to_pulse_len", timeout, 0);

    // turn_end on the expiry edge, player 1
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("tmr_p1_num_1", num_1, 1);
    idle(14);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle(1);
    chk("te_exp_timeout", timeout, 0);
    chk("te_exp_view", num_1, 3);
    idle(2);

    // restart mid-count
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(9);
    chk("mid_num_2", num_2, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("reload_num_2", num_2, 3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // saturation
    repeat (20) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("sat_score_p2", score_p2, 15);
    idle(1);
    chk("sat_num_2", num_2, 15);

    // game_over with a hit in the same cycle, then hits in END
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("go_hit_p1", score_p1, 4);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 1);
      chk("blink_de", disp_en, blink_tab[i]);
      chk("end_num_1", num_1, 4);
    end
    chk("end_frozen_p1", score_p1, 4);
    chk("end_frozen_p2", score_p2, 15);

    // game_start clears, hits in that cycle dropped
    cyc(0, 1, 0, 0, 0, 1, 1);
    chk("gs_clear_p1", score_p1, 0);
    chk("gs_clear_p2", score_p2, 0);
    idle(1);
    chk("gs_view_n1", num_1, 0);
    chk("gs_view_de", disp_en, 1);

    // reset mid-TIMER, then IDLE ignores everything but game_start
    player_sel = 1'b1;
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_tmr_n1", num_1, 0);
    chk("rst_tmr_n2", num_2, 0);
    chk("rst_tmr_de", disp_en, 0);
    chk("rst_tmr_to", timeout, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("idle_hit_p1", score_p1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(2);
    chk("idle_ign_de", disp_en, 0);
    chk("idle_ign_n1", num_1, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
